// File: rtl/bsg_fifo_rolly_replay_ctrl_if.sv
// Read-side bundle between a rollback-capable FIFO, the replay sequencer and
// the downstream consumer. The master modport is the sequencer's view.
interface bsg_fifo_rolly_replay_ctrl_if #(
  parameter int width_p   = 8,
  parameter int lg_size_p = 3,
  parameter int retry_w_p = 2
);
  logic                 fifo_v_i;
  logic [width_p-1:0]   fifo_data_i;
  logic                 fifo_yumi_o;
  logic                 incr_v_o;
  logic                 rollback_v_o;
  logic                 ack_v_o;
  logic                 issue_v_o;
  logic [width_p-1:0]   issue_data_o;
  logic                 issue_ready_i;
  logic                 resp_v_i;
  logic [1:0]           resp_code_i;
  logic [lg_size_p:0]   outstanding_o;
  logic [retry_w_p-1:0] retry_cnt_o;
  logic                 error_o;

  modport master (
    input  fifo_v_i, fifo_data_i, issue_ready_i, resp_v_i, resp_code_i,
    output fifo_yumi_o, incr_v_o, rollback_v_o, ack_v_o, issue_v_o,
           issue_data_o, outstanding_o, retry_cnt_o, error_o
  );

  modport slave (
    output fifo_v_i, fifo_data_i, issue_ready_i, resp_v_i, resp_code_i,
    input  fifo_yumi_o, incr_v_o, rollback_v_o, ack_v_o, issue_v_o,
           issue_data_o, outstanding_o, retry_cnt_o, error_o
  );
endinterface

// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Replay sequencer: issues FIFO entries downstream, checkpoints on OK/COMMIT,
// rolls the FIFO read pointer back after a NACK, and locks up after too many retries.
module bsg_fifo_rolly_replay_ctrl #(
  parameter int width_p           = 8,
  parameter int lg_size_p         = 3,
  parameter int max_outstanding_p = 4,
  parameter int max_retries_p     = 3,
  localparam int retry_w_lp = (max_retries_p < 1) ? 1 : $clog2(max_retries_p + 1),
  localparam int out_w_lp   = lg_size_p + 1
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_fifo_rolly_replay_ctrl_if.master io
);

  typedef enum logic [1:0] {
    S_ISSUE    = 2'd0,
    S_DRAIN    = 2'd1,
    S_ROLLBACK = 2'd2,
    S_ERROR    = 2'd3
  } state_e;

  localparam logic [1:0] resp_ok_lp     = 2'd0;
  localparam logic [1:0] resp_nack_lp   = 2'd1;
  localparam logic [1:0] resp_commit_lp = 2'd2;

  state_e                state_q, state_d;
  logic [out_w_lp-1:0]   outstanding_q, outstanding_d;
  logic [retry_w_lp-1:0] retry_q, retry_d;

  logic                  ok_now, nack_now, commit_now;
  logic                  issue_v, yumi, incr_v, ack_v, rollback_v;
  logic [width_p-1:0]    head_data;

  assign ok_now     = io.resp_v_i & (io.resp_code_i == resp_ok_lp);
  assign nack_now   = io.resp_v_i & (io.resp_code_i == resp_nack_lp);
  assign commit_now = io.resp_v_i & (io.resp_code_i == resp_commit_lp);

  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    retry_d       = retry_q;
    issue_v       = 1'b0;
    yumi          = 1'b0;
    incr_v        = 1'b0;
    ack_v         = 1'b0;
    rollback_v    = 1'b0;

    unique case (state_q)
      S_ISSUE: begin
        // A NACK or COMMIT this cycle blocks issue so the new entry is not
        // swept into the drain/commit that the response starts.
        issue_v = io.fifo_v_i & (outstanding_q < out_w_lp'(max_outstanding_p))
                  & ~nack_now & ~commit_now;
        yumi    = issue_v & io.issue_ready_i;
        if (commit_now) begin
          ack_v         = 1'b1;
          outstanding_d = '0;
          retry_d       = '0;
        end else if (nack_now) begin
          if (retry_q == retry_w_lp'(max_retries_p)) begin
            state_d = S_ERROR;
          end else begin
            outstanding_d = outstanding_q - out_w_lp'(1);
            state_d = (outstanding_q == out_w_lp'(1)) ? S_ROLLBACK : S_DRAIN;
          end
        end else begin
          outstanding_d = outstanding_q + out_w_lp'(yumi) - out_w_lp'(ok_now);
          if (ok_now) begin
            incr_v  = 1'b1;
            retry_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (io.resp_v_i) begin
          outstanding_d = outstanding_q - out_w_lp'(1);
          if (outstanding_q == out_w_lp'(1)) state_d = S_ROLLBACK;
        end
      end
      S_ROLLBACK: begin
        rollback_v = 1'b1;
        retry_d    = retry_q + retry_w_lp'(1);
        state_d    = S_ISSUE;
      end
      default: ;
    endcase

    if (!reset_n_i) begin
      issue_v    = 1'b0;
      yumi       = 1'b0;
      incr_v     = 1'b0;
      ack_v      = 1'b0;
      rollback_v = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_ISSUE;
      outstanding_q <= '0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      retry_q       <= retry_d;
    end
  end

  assign head_data       = io.fifo_data_i;
  assign io.issue_data_o = head_data;
  assign io.issue_v_o    = issue_v;
  assign io.fifo_yumi_o  = yumi;
  assign io.incr_v_o     = incr_v;
  assign io.ack_v_o      = ack_v;
  assign io.rollback_v_o = rollback_v;
  assign io.outstanding_o = outstanding_q;
  assign io.retry_cnt_o  = retry_q;
  assign io.error_o      = (state_q == S_ERROR);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && state_q != S_ERROR && io.resp_v_i) begin
      assert (outstanding_q != '0) else $error("response with nothing outstanding");
      assert (io.resp_code_i != 2'd3) else $error("reserved response code");
      assert (!(state_q == S_DRAIN && commit_now)) else $error("COMMIT_ALL while draining");
      assert (state_q != S_ROLLBACK) else $error("response during rollback");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_ctrl.sv
// Bench: a queue-based model of the rollback FIFO and of the in-flight window
// predicts every output each cycle; directed scenarios pin the model.
module tb_bsg_fifo_rolly_replay_ctrl;
  localparam int W = 8, LG = 3, MAXO = 4, MAXR = 3, RW = 2, DEPTH = 8;
  localparam int M_I = 0, M_D = 1, M_R = 2, M_E = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_fifo_rolly_replay_ctrl_if #(.width_p(W), .lg_size_p(LG), .retry_w_p(RW)) io ();

  bsg_fifo_rolly_replay_ctrl #(
    .width_p(W), .lg_size_p(LG), .max_outstanding_p(MAXO), .max_retries_p(MAXR)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .io(io)
  );

  // FIFO model: write, read and checkpoint pointers as plain counters
  logic [W-1:0] mem [DEPTH];
  int wptr, rptr, cptr, seq;
  logic [W-1:0] inflight [$];
  logic [W-1:0] golden [$];
  int m_state, m_retry;
  int compared, mismatched;
  int n_yumi, n_incr, n_ack, n_rb, peak;
  bit last_yumi, last_ack;
  logic [W-1:0] last_issued;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic retire_ok();
    if (golden.size() == 0) begin
      chk("golden_nonempty", 0, 1);
    end else begin
      chk("retire_data", int'(inflight[0]), int'(golden[0]));
      void'(golden.pop_front());
    end
    void'(inflight.pop_front());
  endtask

  task automatic cycle(input int npush, input bit rdy, input bit rv, input int rc);
    bit e_iss, e_yumi, e_incr, e_ack, e_rb, ok, nack, commit;
    logic [W-1:0] head;
    for (int i = 0; i < npush; i++) begin
      if (wptr - cptr < DEPTH) begin
        mem[wptr % DEPTH] = W'(seq);
        golden.push_back(W'(seq));
        seq++;
        wptr++;
      end
    end
    head = mem[rptr % DEPTH];
    io.fifo_v_i      = (rptr != wptr);
    io.fifo_data_i   = head;
    io.issue_ready_i = rdy;
    io.resp_v_i      = rv;
    io.resp_code_i   = 2'(rc);
    #2;
    ok = rv && rc == 0; nack = rv && rc == 1; commit = rv && rc == 2;
    e_iss = 0; e_yumi = 0; e_incr = 0; e_ack = 0; e_rb = 0;
    if (reset_n) begin
      if (m_state == M_I) begin
        e_iss  = (rptr != wptr) && inflight.size() < MAXO && !nack && !commit;
        e_yumi = e_iss && rdy;
        e_incr = ok;
        e_ack  = commit;
      end else if (m_state == M_R) begin
        e_rb = 1;
      end
    end
    chk("issue_v", int'(io.issue_v_o), int'(e_iss));
    chk("yumi", int'(io.fifo_yumi_o), int'(e_yumi));
    chk("incr", int'(io.incr_v_o), int'(e_incr));
    chk("ack", int'(io.ack_v_o), int'(e_ack));
    chk("rollback", int'(io.rollback_v_o), int'(e_rb));
    chk("outstanding", int'(io.outstanding_o), inflight.size());
    chk("retry", int'(io.retry_cnt_o), m_retry);
    chk("error", int'(io.error_o), int'(m_state == M_E));
    if (e_iss) chk("issue_data", int'(io.issue_data_o), int'(head));

    n_yumi += int'(io.fifo_yumi_o); n_incr += int'(io.incr_v_o);
    n_ack += int'(io.ack_v_o); n_rb += int'(io.rollback_v_o);
    if (int'(io.outstanding_o) > peak) peak = int'(io.outstanding_o);
    last_yumi = io.fifo_yumi_o; last_ack = io.ack_v_o;
    if (io.fifo_yumi_o) last_issued = io.issue_data_o;

    if (!reset_n) begin
      m_state = M_I; m_retry = 0; inflight.delete(); golden.delete();
      wptr = 0; rptr = 0; cptr = 0;
    end else begin
      case (m_state)
        M_I: begin
          if (commit) begin
            while (inflight.size() > 0) retire_ok();
            m_retry = 0;
          end else if (nack) begin
            if (m_retry == MAXR) m_state = M_E;
            else begin
              void'(inflight.pop_front());
              m_state = (inflight.size() == 0) ? M_R : M_D;
            end
          end else if (ok) begin
            retire_ok();
            m_retry = 0;
          end
          if (e_yumi) begin inflight.push_back(io.issue_data_o); rptr++; end
          if (e_incr) cptr++;
          if (e_ack) cptr = rptr;
        end
        M_D: if (rv) begin
          void'(inflight.pop_front());
          if (inflight.size() == 0) m_state = M_R;
        end
        M_R: begin rptr = cptr; m_retry++; m_state = M_I; end
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    n_yumi = 0; n_incr = 0; n_ack = 0; n_rb = 0; peak = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    reset_n = 1'b1;
    clr_cnt();
  endtask

  initial begin
    int base, err_cycles, r, rc, np;
    bit rv, rdy;
    compared = 0; mismatched = 0; seq = 0; err_cycles = 0;
    wptr = 0; rptr = 0; cptr = 0; m_state = M_I; m_retry = 0;
    last_issued = '0;
    io.fifo_v_i = 0; io.fifo_data_i = '0; io.issue_ready_i = 0;
    io.resp_v_i = 0; io.resp_code_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // streaming with OK one cycle after each issue
    cycle(4, 1, 0, 0);
    repeat (4) cycle(0, 1, 1, 0);
    chk("t1_yumi", n_yumi, 4); chk("t1_incr", n_incr, 4);
    chk("t1_peak", peak, 1); chk("t1_out", int'(io.outstanding_o), 0);
    chk("t1_rb", n_rb, 0);

    // in-flight limit
    do_reset(); base = seq;
    cycle(6, 1, 0, 0);
    repeat (5) cycle(0, 1, 0, 0);
    chk("t2_yumi", n_yumi, 4); chk("t2_out", int'(io.outstanding_o), 4);
    chk("t2_issue_v", int'(io.issue_v_o), 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    chk("t2_yumi5", n_yumi, 5); chk("t2_fifth", int'(last_issued), (base + 4) % 256);

    // NACK in the middle, drain, rollback, replay of B
    do_reset(); base = seq;
    cycle(3, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    chk("t3_retry", int'(io.retry_cnt_o), 1); chk("t3_rb", n_rb, 1);
    chk("t3_incr", n_incr, 1);
    cycle(0, 1, 0, 0);
    chk("t3_replay", int'(last_issued), (base + 1) % 256);

    // COMMIT_ALL with FIFO still valid
    do_reset();
    cycle(4, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 2);
    chk("t4_ack", int'(last_ack), 1); chk("t4_noyumi", int'(last_yumi), 0);
    chk("t4_out", int'(io.outstanding_o), 0); chk("t4_retry", int'(io.retry_cnt_o), 0);

    // retry exhaustion
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle((k == 0) ? 1 : 0, 1, 0, 0);
      cycle(0, 0, 1, 1);
      if (k < 3) cycle(0, 0, 0, 0);
    end
    chk("t5_rb", n_rb, 3); chk("t5_err", int'(io.error_o), 1);
    chk("t5_retry", int'(io.retry_cnt_o), 3);
    repeat (3) cycle(0, 1, 0, 0);
    chk("t5_issue_v", int'(io.issue_v_o), 0);

    // reset in the middle of a drain
    do_reset();
    cycle(3, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 1);
    chk("t6_out_pre", int'(io.outstanding_o), 2);
    reset_n = 1'b0;
    cycle(0, 1, 0, 0);
    reset_n = 1'b1;
    chk("t6_out", int'(io.outstanding_o), 0); chk("t6_err", int'(io.error_o), 0);
    chk("t6_retry", int'(io.retry_cnt_o), 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      np = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rdy = ($urandom_range(0, 3) != 0);
      rv = 0; rc = 0;
      if (m_state == M_I && inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        rv = 1; r = $urandom_range(0, 99);
        rc = (r < 75) ? 0 : (r < 88) ? 1 : 2;
      end else if (m_state == M_D && $urandom_range(0, 1) == 1) begin
        rv = 1; rc = $urandom_range(0, 1);
      end else if (m_state == M_E && $urandom_range(0, 1) == 1) begin
        rv = 1; rc = $urandom_range(0, 2);
      end
      err_cycles = (m_state == M_E) ? err_cycles + 1 : 0;
      if (err_cycles > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        err_cycles = 0;
      end else begin
        cycle(np, rdy, rv, rc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bsg_fifo_rolly_replay_ctrl.md
Name: bsg_fifo_rolly_replay_ctrl

Overview:
Read-side sequencer for a rollback-capable 1r1w FIFO. It issues FIFO entries to a downstream consumer that returns in-order per-entry responses. It drives the FIFO read-side controls: incr on each accepted entry, ack on bulk commit, and rollback with replay on a NACK. It bounds in-flight entries and retry attempts, and halts with a sticky error once retries are exhausted.

Parameters:
width_p, (required), entry data width
lg_size_p, (required), log2 of FIFO depth; outstanding count never exceeds 2^lg_size_p
max_outstanding_p, 4, maximum issued-but-unresolved entries; 1..2^lg_size_p
max_retries_p, 3, rollbacks allowed before error; retry counter width is clog2(max_retries_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
fifo_v_i  in  1  FIFO head valid
fifo_data_i  in  width_p  FIFO head data
fifo_yumi_o  out  1  dequeue FIFO head
incr_v_o  out  1  advance FIFO read checkpoint by 1
rollback_v_o  out  1  reset FIFO read pointer to read checkpoint
ack_v_o  out  1  forward FIFO read checkpoint to read pointer
issue_v_o  out  1  entry offered downstream
issue_data_o  out  width_p  entry data (= fifo_data_i)
issue_ready_i  in  1  downstream accepts
resp_v_i  in  1  response valid, in issue order
resp_code_i  in  2  0=OK, 1=NACK, 2=COMMIT_ALL, 3=reserved
outstanding_o  out  lg_size_p+1  current in-flight count
retry_cnt_o  out  clog2(max_retries_p+1)  current retry count
error_o  out  1  sticky retry-exhausted flag

Behaviour:
- Reset (reset_n_i=0 at posedge): state=ISSUE, outstanding=0, retry=0, error_o=0. While in reset, all control outputs are 0.
- States: ISSUE, DRAIN, ROLLBACK, ERROR.
- ISSUE:
  - issue_v_o = fifo_v_i & (outstanding < max_outstanding_p) & ~nack_now & ~commit_now.
  - fifo_yumi_o = issue_v_o & issue_ready_i. A yumi increments outstanding.
  - OK response: incr_v_o=1 that cycle, outstanding -1, retry cleared to 0.
  - COMMIT_ALL response: ack_v_o=1, outstanding set to 0 (a same-cycle issue is blocked by the issue_v_o gating), retry cleared.
  - NACK response, retry < max_retries_p: outstanding -1, go to DRAIN; if outstanding becomes 0, go directly to ROLLBACK.
  - NACK response, retry == max_retries_p: go to ERROR.
  - Issue plus OK in the same cycle: outstanding unchanged, incr_v_o=1.
- DRAIN: no issue. Each response (any code) decrements outstanding and generates no incr or ack. When outstanding reaches 0, go to ROLLBACK.
- ROLLBACK: exactly one cycle. rollback_v_o=1, issue_v_o=0, retry +1, then return to ISSUE. Replay restarts at the oldest un-incr'd entry.
- ERROR: all control outputs 0, error_o=1, responses ignored. Exit only by reset.
- Exclusivity: incr_v_o, rollback_v_o and ack_v_o are mutually exclusive every cycle. ack never coincides with incr or rollback.
- Latency: response to incr/ack is combinational (same cycle). NACK to rollback_v_o takes at least 1 cycle.
- Illegal inputs (assert, translate_off): resp_v_i with outstanding==0; code 3; COMMIT_ALL in DRAIN; resp_v_i while in ROLLBACK.
- Reset mid-DRAIN/ROLLBACK: all state returns to reset values. The FIFO is reset by the same reset.

Test Plan:
- Reset, then 4 entries (A..D) with issue_ready_i=1 and OK responses one cycle after each issue -> 4 yumi, 4 incr_v_o pulses, outstanding peaks at 1 and ends at 0, no rollback.
- max_outstanding_p=4, 6 entries queued, no responses -> exactly 4 issued, then issue_v_o=0 with fifo_v_i=1 and outstanding_o=4; one OK -> 5th issued.
- Issue A,B,C; responses OK(A), NACK(B), OK(C) -> incr once, DRAIN, C response ignored, one rollback_v_o pulse, retry_cnt_o=1, B reissued next.
- Issue 3 entries, COMMIT_ALL while fifo_v_i=1 -> ack_v_o=1, no yumi that cycle, outstanding_o=0, retry_cnt_o=0.
- max_retries_p=3, NACK the same entry 4 times -> 3 rollbacks, then ERROR: error_o=1, issue_v_o held 0 until reset_n_i=0.
- Assert reset_n_i=0 during DRAIN with outstanding=2 -> next cycle outstanding_o=0, state ISSUE, all control outputs 0.
